// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared constants and FSM state type for the UART command sequencer.
// Optional write acknowledge is selected with the UART_CMD_ACK_EN macro.
package uart_cmd_pkg;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1_000_000;
  localparam logic [7:0]  OP_WRITE            = 8'h01;
  localparam logic [7:0]  OP_READ             = 8'h02;
  localparam logic [7:0]  ACK_BYTE            = 8'h06;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_LEN,
    S_WR_DATA,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_TX_START,
    S_TX_GUARD,
    S_TX_WAIT
  } state_t;

  // Frame-receive states: inter-byte timeout applies here
  function automatic logic is_rx_state(input state_t s);
    return (s == S_GET_ADDR) || (s == S_GET_LEN) || (s == S_WR_DATA);
  endfunction

  // Read/transmit states: stray RX bytes are dropped with an error
  function automatic logic is_busy_state(input state_t s);
    return (s == S_RD_ISSUE) || (s == S_RD_WAIT) || (s == S_TX_START) ||
           (s == S_TX_GUARD) || (s == S_TX_WAIT);
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timeout.sv
// Inter-byte timeout: down-counter reloaded on each byte and while disabled,
// pulsing expire on the TIMEOUT_CYC-th consecutive idle enabled cycle.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic en,
  input  logic reload,
  output logic expire
);

  localparam int unsigned   CW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] RELOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!en || reload) begin
      cnt_d = RELOAD_VAL;
    end else if (cnt_q == '0) begin
      expire = 1'b1;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) cnt_q <= RELOAD_VAL;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Framed UART command parser driving register writes/reads and returning read data over TX.
// Define UART_CMD_ACK_EN to send ACK_BYTE after every completed write frame.
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC = uart_cmd_pkg::TIMEOUT_CYC_DEFAULT,
  parameter logic [7:0]  OP_WRITE    = uart_cmd_pkg::OP_WRITE,
  parameter logic [7:0]  OP_READ     = uart_cmd_pkg::OP_READ
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);

  import uart_cmd_pkg::*;

  state_t     state_q, state_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       to_expire;

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .sysclk (sysclk),
    .rst    (rst),
    .en     (is_rx_state(state_q)),
    .reload (rx_valid),
    .expire (to_expire)
  );

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    tx_data_d = tx_data_q;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    tx_start  = 1'b0;
    err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE) begin
            is_rd_d = 1'b0;
            state_d = S_GET_ADDR;
          end else if (rx_data == OP_READ) begin
            is_rd_d = 1'b1;
            state_d = S_GET_ADDR;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = S_GET_LEN;
        end else if (to_expire) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GET_LEN: begin
        if (rx_valid) begin
          rem_d = rx_data;
          if (rx_data == '0) begin
`ifdef UART_CMD_ACK_EN
            if (!is_rd_q) begin
              tx_data_d = ACK_BYTE;
              state_d   = S_TX_START;
            end else begin
              state_d   = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = is_rd_q ? S_RD_ISSUE : S_WR_DATA;
          end
        end else if (to_expire) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (rx_valid) begin
          reg_we = 1'b1;
          addr_d = addr_q + 8'd1;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
`ifdef UART_CMD_ACK_EN
            tx_data_d = ACK_BYTE;
            state_d   = S_TX_START;
`else
            state_d   = S_IDLE;
`endif
          end
        end else if (to_expire) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        reg_re  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tx_data_d = reg_rdata;
        state_d   = S_TX_START;
      end
      S_TX_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_TX_GUARD;
        end
      end
      // tx_busy only rises the cycle after tx_start, so skip one sample
      S_TX_GUARD: state_d = S_TX_WAIT;
      S_TX_WAIT: begin
        if (!tx_busy) begin
          if (is_rd_q) begin
            addr_d  = addr_q + 8'd1;
            rem_d   = rem_q - 8'd1;
            state_d = (rem_q == 8'd1) ? S_IDLE : S_RD_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_valid && is_busy_state(state_q)) err = 1'b1;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = reg_we ? rx_data : '0;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a register-file model and a mock transmitter.
// Define UART_CMD_ACK_EN for both RTL and bench to cover the write-acknowledge build.
module tb_uart_cmd_sequencer;

  localparam int unsigned TO = 64;
`ifdef UART_CMD_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = '0;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .sysclk    (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err       (err)
  );

  // Register file and transmitter models
  logic [7:0] mem [256] = '{default: 8'h00};
  int         tx_cnt = 0;
  assign tx_busy = (tx_cnt != 0);

  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (tx_start)        tx_cnt <= 5;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  // Bus/TX logging, sampled mid-cycle
  logic [7:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], tx_q[$];
  int         lat_q[$];
  int         cyc = 0, re_cyc = 0, err_cnt = 0, tx_unstable = 0;
  bit         re_pend = 1'b0;
  logic [7:0] tx_hold = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reg_we) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
    end
    if (reg_re) begin
      rd_addr_q.push_back(reg_addr);
      re_cyc  = cyc;
      re_pend = 1'b1;
    end
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_hold = tx_data;
      if (re_pend) lat_q.push_back(cyc - re_cyc);
      re_pend = 1'b0;
    end else if (tx_busy && tx_data !== tx_hold) begin
      tx_unstable = tx_unstable + 1;
    end
    if (err) err_cnt = err_cnt + 1;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_data = '0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
    gap(8);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
    lat_q.delete();
    err_cnt = 0;
  endtask

  typedef struct {
    logic [55:0] bytes;   // frame, first byte in MSBs
    int          n;
    logic [7:0]  fa;      // first register address touched
    int          n_we;
    int          n_re;
    logic [31:0] tx;      // expected TX bytes, first in MSBs
    int          n_tx;
    int          n_err;
    bit          ack;     // complete write frame
  } vec_t;

  function automatic vec_t mk(input logic [55:0] bytes, input int n, input logic [7:0] fa,
                              input int n_we, input int n_re, input logic [31:0] tx,
                              input int n_tx, input int n_err, input bit ack);
    vec_t v;
    v.bytes = bytes; v.n = n; v.fa = fa; v.n_we = n_we; v.n_re = n_re;
    v.tx = tx; v.n_tx = n_tx; v.n_err = n_err; v.ack = ack;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    vec_t       v;
    logic [7:0] ea, eb;
    int         exp_ntx;
    logic [31:0] exp_tx;

    vecs[0] = mk(56'h01_00_04_01_02_03_04, 7, 8'h00, 4, 0, 32'h0, 0, 0, 1'b1);
    vecs[1] = mk(56'h02_00_04_00_00_00_00, 3, 8'h00, 0, 4, 32'h01020304, 4, 0, 1'b0);
    vecs[2] = mk(56'h05_00_00_00_00_00_00, 1, 8'h00, 0, 0, 32'h0, 0, 1, 1'b0);
    vecs[3] = mk(56'h02_00_01_00_00_00_00, 3, 8'h00, 0, 1, 32'h01000000, 1, 0, 1'b0);
    vecs[4] = mk(56'h01_10_00_00_00_00_00, 3, 8'h10, 0, 0, 32'h0, 0, 0, 1'b1);
    vecs[5] = mk(56'h02_10_00_00_00_00_00, 3, 8'h10, 0, 0, 32'h0, 0, 0, 1'b0);
    vecs[6] = mk(56'h01_FE_03_AA_BB_CC_00, 6, 8'hFE, 3, 0, 32'h0, 0, 0, 1'b1);
    vecs[7] = mk(56'h02_FE_03_00_00_00_00, 3, 8'hFE, 0, 3, 32'hAABBCC00, 3, 0, 1'b0);

    // Reset state
    gap(3);
    chk("rst_ctrl", {28'd0, busy, err, tx_start, reg_we}, 32'd0);
    chk("rst_data", {8'd0, tx_data, reg_addr, reg_wdata}, 32'd0);
    chk("rst_re", {31'd0, reg_re}, 32'd0);
    rst = 1'b0;
    gap(3);

    for (int vi = 0; vi < NV; vi++) begin
      v = vecs[vi];
      clear_logs();
      for (int i = 0; i < v.n; i++) begin
        send_byte(v.bytes[55-8*i -: 8]);
        gap(3);
      end
      wait_idle();
      exp_ntx = v.n_tx;
      exp_tx  = v.tx;
      if (ACK && v.ack) begin
        exp_ntx = 1;
        exp_tx  = 32'h06000000;
      end
      chk($sformatf("v%0d_n_we", vi), wr_addr_q.size(), v.n_we);
      for (int i = 0; i < v.n_we && i < wr_addr_q.size(); i++) begin
        ea = v.fa + 8'(i);
        eb = v.bytes[55-8*(i+3) -: 8];
        chk($sformatf("v%0d_wr_addr%0d", vi, i), {24'd0, wr_addr_q[i]}, {24'd0, ea});
        chk($sformatf("v%0d_wr_data%0d", vi, i), {24'd0, wr_data_q[i]}, {24'd0, eb});
      end
      chk($sformatf("v%0d_n_re", vi), rd_addr_q.size(), v.n_re);
      for (int i = 0; i < v.n_re && i < rd_addr_q.size(); i++) begin
        ea = v.fa + 8'(i);
        chk($sformatf("v%0d_rd_addr%0d", vi, i), {24'd0, rd_addr_q[i]}, {24'd0, ea});
      end
      chk($sformatf("v%0d_n_tx", vi), tx_q.size(), exp_ntx);
      for (int i = 0; i < exp_ntx && i < tx_q.size(); i++) begin
        eb = exp_tx[31-8*i -: 8];
        chk($sformatf("v%0d_tx%0d", vi, i), {24'd0, tx_q[i]}, {24'd0, eb});
      end
      chk($sformatf("v%0d_n_err", vi), err_cnt, v.n_err);
      foreach (lat_q[i]) chk($sformatf("v%0d_rd_lat%0d", vi, i), lat_q[i], 2);
    end

    // Partial frame times out after TO idle cycles, not earlier
    clear_logs();
    send_byte(8'h01); gap(3);
    send_byte(8'h00);
    gap(TO - 2);
    chk("to_early_busy", {31'd0, busy}, 32'd1);
    chk("to_early_err", err_cnt, 0);
    gap(12);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_err", err_cnt, 1);
    chk("to_n_we", wr_addr_q.size(), 0);

    // Bytes arriving exactly at expiry are accepted
    clear_logs();
    send_byte(8'h01); gap(3);
    send_byte(8'h20);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h01);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h5A);
    wait_idle();
    chk("edge_err", err_cnt, 0);
    chk("edge_n_we", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      chk("edge_wr_addr", {24'd0, wr_addr_q[0]}, 32'h20);
      chk("edge_wr_data", {24'd0, wr_data_q[0]}, 32'h5A);
    end

    // Stray byte during a read is dropped with an error; read completes
    clear_logs();
    send_byte(8'h02); gap(3);
    send_byte(8'hFE); gap(3);
    send_byte(8'h04); gap(3);
    send_byte(8'h03);
    wait_idle();
    chk("stray_err", err_cnt, 1);
    chk("stray_n_tx", tx_q.size(), 4);
    exp_tx = 32'hAABBCC02;
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      eb = exp_tx[31-8*i -: 8];
      chk($sformatf("stray_tx%0d", i), {24'd0, tx_q[i]}, {24'd0, eb});
    end

    // Reset mid-write keeps committed writes
    clear_logs();
    send_byte(8'h01); gap(3);
    send_byte(8'h40); gap(3);
    send_byte(8'h04); gap(3);
    send_byte(8'h11); gap(3);
    send_byte(8'h22); gap(3);
    chk("mid_n_we", wr_addr_q.size(), 2);
    rst = 1'b1;
    gap(2);
    chk("mid_rst_ctrl", {28'd0, busy, err, tx_start, reg_we}, 32'd0);
    chk("mid_rst_data", {8'd0, tx_data, reg_addr, reg_wdata}, 32'd0);
    rst = 1'b0;
    gap(3);
    clear_logs();
    send_byte(8'h02); gap(3);
    send_byte(8'h40); gap(3);
    send_byte(8'h02);
    wait_idle();
    chk("mid_n_tx", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      chk("mid_tx0", {24'd0, tx_q[0]}, 32'h11);
      chk("mid_tx1", {24'd0, tx_q[1]}, 32'h22);
    end
    chk("mid_err", err_cnt, 0);

    chk("tx_stable", tx_unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
